// File: rtl/zebra_frame_writer.sv
// Thresholds a raster luma stream into 2-bit black/white codes and writes one frame to BRAM, then holds until the detector is done.
// Write appears one cycle after each accepted pixel; pix_ready drops from the LAST write until detection_valid releases the frame.
module zebra_frame_writer #(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int THRESHOLD  = 128,
  localparam int ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT),
  localparam int LAST       = IMG_WIDTH*IMG_HEIGHT-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [1:0]        bram_wdata,
  output logic              valid_to_read,
  input  logic              detection_valid,
  output logic              frame_error,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, WAIT_DET} state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [7:0]        THR    = 8'(THRESHOLD);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic [1:0]        code;

  assign pix_ready = (state == IDLE) || (state == WRITE);
  assign xfer      = pix_valid && pix_ready;
  assign code      = (pix_data >= THR) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      bram_we       <= 1'b0;
      bram_waddr    <= '0;
      bram_wdata    <= 2'b00;
      valid_to_read <= 1'b0;
      frame_error   <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      bram_we     <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && pix_sof) begin
            bram_we    <= 1'b1;
            bram_waddr <= '0;
            bram_wdata <= code;
            addr       <= ONE_A;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (xfer) begin
            bram_we    <= 1'b1;
            bram_wdata <= code;
            if (pix_sof) begin
              // early start of frame: restart at pixel 0, even on the LAST slot
              bram_waddr  <= '0;
              addr        <= ONE_A;
              frame_error <= 1'b1;
            end else begin
              bram_waddr <= addr;
              if (addr == LAST_A) begin
                addr  <= '0;
                state <= FLUSH;
              end else begin
                addr <= addr + ONE_A;
              end
            end
          end
        end
        FLUSH: begin
          state         <= WAIT_DET;
          valid_to_read <= 1'b1;
          frame_count   <= frame_count + 8'd1;
        end
        WAIT_DET: begin
          if (detection_valid) begin
            state         <= IDLE;
            valid_to_read <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zebra_frame_writer.sv
// Randomized bench for zebra_frame_writer against a frame-position reference model.
module tb_zebra_frame_writer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int THR   = 128;
  localparam int AW    = $clog2(W*H);
  localparam int LASTI = W*H-1;
  localparam int VW    = 14 + AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid, pix_sof, detection_valid;
  logic [7:0]    pix_data;
  logic          pix_ready, bram_we, valid_to_read, frame_error;
  logic [AW-1:0] bram_waddr;
  logic [1:0]    bram_wdata;
  logic [7:0]    frame_count;

  always #5 clk = ~clk;

  zebra_frame_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .valid_to_read(valid_to_read), .detection_valid(detection_valid),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position of the next pixel in the frame (-1 = waiting for sof),
  // plus whether the frame is finishing or waiting for the detector.
  int       m_pos;
  bit       m_flush, m_wait;
  int       m_fc;
  bit       e_we, e_err;
  int       e_addr;
  bit [1:0] e_data;

  typedef struct { bit v; logic [7:0] d; bit s; bit det; } stim_t;
  stim_t q[$];

  function automatic void model_reset();
    m_pos = -1; m_flush = 0; m_wait = 0; m_fc = 0;
    e_we = 0; e_err = 0; e_addr = 0; e_data = 2'b00;
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {!(m_flush || m_wait), e_we, e_we ? AW'(e_addr) : {AW{1'b0}},
            e_we ? e_data : 2'b00, m_wait, e_err, 8'(m_fc)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {pix_ready, bram_we, e_we ? bram_waddr : {AW{1'b0}},
            e_we ? bram_wdata : 2'b00, valid_to_read, frame_error, frame_count};
  endfunction

  function automatic logic [12+AW-1:0] rst_vec();
    return {bram_we, bram_waddr, bram_wdata, valid_to_read, frame_error, frame_count};
  endfunction

  // One clock: drive at negedge, advance model, return at the following negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit s, input bit det);
    pix_valid = v; pix_data = d; pix_sof = s; detection_valid = det;
    e_we = 0; e_err = 0;
    if (m_wait) begin
      if (det) m_wait = 0;
    end else if (m_flush) begin
      m_flush = 0; m_wait = 1; m_fc = (m_fc + 1) % 256;
    end else if (v) begin
      e_data = (d >= THR) ? 2'b01 : 2'b00;
      if (s) begin
        e_we = 1; e_addr = 0; e_err = (m_pos >= 0); m_pos = 1;
      end else if (m_pos >= 0) begin
        e_we = 1; e_addr = m_pos;
        if (m_pos == LASTI) begin m_pos = -1; m_flush = 1; end
        else m_pos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input bit v, input logic [7:0] d, input bit s, input bit det);
    stim_t t;
    t.v = v; t.d = d; t.s = s; t.det = det;
    q.push_back(t);
  endtask

  task automatic push_frame(input bit toggle);
    for (int i = 0; i <= LASTI; i++) begin
      push(1, 8'($urandom), i == 0, 0);
      if (toggle) push(0, 8'($urandom), 0, 0);
    end
    repeat (3) push(0, 0, 0, 0);
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rst_vec() !== '0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", rst_vec());
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_frame();
    logic [7:0] px [8] = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd10, 8'd200, 8'd128, 8'd0};
    for (int i = 0; i < 8; i++) push(1, px[i], i == 0, 0);
    repeat (3) push(0, 0, 0, 0);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL frame step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (frame_count !== 8'd1) begin
      errors++; $display("FAIL frame_count got=%0d exp=1", frame_count);
    end
  endtask

  task automatic test_wait_hold();
    for (int i = 0; i < 20; i++) push(1, 8'($urandom), 1'($urandom), 0);
    push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL wait_hold step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_no_sof();
    repeat (3) push(1, 8'($urandom), 0, 0);
    push_frame(0);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL no_sof step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_restart();
    push(1, 8'($urandom), 1, 0);
    repeat (4) push(1, 8'($urandom), 0, 0);
    push_frame(0);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL restart step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_toggle();
    push_frame(1);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL toggle step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'($urandom), i == 0, 0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL mid_pre step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    // pixel 3 is accepted, then reset lands while its write is on the bus
    pix_valid = 1; pix_data = 8'hff; pix_sof = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (rst_vec() !== '0) begin
      errors++; $display("FAIL reset_mid got=%h exp=0", rst_vec());
    end
    @(negedge clk);
    pix_valid = 0; rst = 0;
    model_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(i < 8, 8'($urandom), i == 0, 0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL mid_frame step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    #3 rst = 1;
    #1;
    checks++;
    if (rst_vec() !== '0) begin
      errors++; $display("FAIL reset_wait got=%h exp=0", rst_vec());
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL reset_wait_release got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_wrap();
    int start_fc = m_fc;
    for (int f = 0; f < 256; f++) push_frame(0);
    for (int i = 0; q.size() > 0; i++) begin
      stim_t t = q.pop_front();
      cycle(t.v, t.d, t.s, t.det);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL wrap step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (frame_count !== 8'(start_fc)) begin
      errors++; $display("FAIL wrap_count got=%0d exp=%0d", frame_count, start_fc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 12) == 0, ($urandom % 6) == 0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random step%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    rst = 1; pix_valid = 0; pix_data = 0; pix_sof = 0; detection_valid = 0;
    model_reset();
    test_reset();
    test_frame();
    test_wait_hold();
    test_no_sof();
    test_restart();
    test_toggle();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zebra_frame_writer.md
ZEBRA_FRAME_WRITER -- requirements
Module: zebra_frame_writer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, frame height in pixels.
REQ-003 SHALL have parameter THRESHOLD, default 128, white threshold for 8-bit luma.
REQ-004 SHALL use ADDR_W = $clog2(IMG_WIDTH*IMG_HEIGHT) and LAST = IMG_WIDTH*IMG_HEIGHT-1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 pix_valid  input  1  upstream pixel valid.
REQ-009 pix_data  input  8  luma sample, raster order.
REQ-010 pix_sof  input  1  marks first pixel of a frame, qualified by pix_valid.
REQ-011 pix_ready  output  1  block accepts pixel this cycle.
REQ-012 bram_we  output  1  BRAM write enable.
REQ-013 bram_waddr  output  ADDR_W  BRAM write address, y*IMG_WIDTH+x.
REQ-014 bram_wdata  output  2  pixel code: 2'b00 black, 2'b01 white.
REQ-015 valid_to_read  output  1  frame in BRAM complete, detector may start.
REQ-016 detection_valid  input  1  one-cycle pulse from detector, frame processing finished.
REQ-017 frame_error  output  1  one-cycle pulse, frame aborted by early pix_sof.
REQ-018 frame_count  output  8  completed frames written, wraps 255->0.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, FLUSH, WAIT_DET.
REQ-020 Transfer SHALL occur when pix_valid && pix_ready at a rising edge.
REQ-021 pix_ready SHALL be 1 in IDLE and WRITE, 0 in FLUSH and WAIT_DET.
REQ-022 IDLE: transfer with pix_sof=0 SHALL be discarded, no write; transfer with pix_sof=1 SHALL be written to address 0 and go to WRITE (address counter = 1).
REQ-023 WRITE: each transfer SHALL be written to the current address counter value, then counter increments.
REQ-024 Write latency: transfer at edge N SHALL produce bram_we=1 with registered bram_waddr/bram_wdata during cycle N+1; bram_we=0 in every other cycle.
REQ-025 bram_wdata SHALL be 2'b01 if pix_data >= THRESHOLD, else 2'b00; 2'b10 (visited) SHALL never be written.
REQ-026 Transfer to address LAST SHALL go to FLUSH; FLUSH SHALL last one cycle (the LAST write) then go to WAIT_DET.
REQ-027 valid_to_read SHALL be 1 in every WAIT_DET cycle only, first asserted the cycle after the LAST write.
REQ-028 frame_count SHALL increment by 1 on FLUSH->WAIT_DET, modulo 256.
REQ-029 WAIT_DET: detection_valid=1 SHALL go to IDLE; valid_to_read low the following cycle.
REQ-030 detection_valid outside WAIT_DET SHALL be ignored.
REQ-031 WRITE: transfer with pix_sof=1 SHALL pulse frame_error for one cycle, write that pixel to address 0, set counter to 1, stay in WRITE; frame_count unchanged.
REQ-032 pix_sof=1 on the transfer to address LAST SHALL be treated as REQ-031 (restart), not completion.
REQ-033 pix_valid=0 in WRITE SHALL hold counter and state indefinitely; no timeout.
REQ-034 Address counter SHALL never exceed LAST; no wrap inside a frame.

Reset
REQ-035 rst=1 SHALL asynchronously force state IDLE, address counter 0, bram_we 0, bram_waddr 0, bram_wdata 0, valid_to_read 0, frame_error 0, frame_count 0; pix_ready reflects IDLE (1) after reset releases.
REQ-036 Reset mid-frame or in WAIT_DET SHALL abandon the frame; a pending write registered before reset SHALL NOT be issued.

Verification
REQ-037 W=4,H=2,THRESHOLD=128; sof then pixels 0,127,128,255,10,200,128,0 back-to-back -> writes addr 0..7 data 00,00,01,01,00,01,01,00 one cycle after each; valid_to_read high cycle after addr-7 write; frame_count=1.
REQ-038 In WAIT_DET, hold pix_valid=1 for 20 cycles -> pix_ready=0, no writes; pulse detection_valid -> valid_to_read low next cycle, pix_ready=1.
REQ-039 Three pixels without sof in IDLE -> no bram_we; next sof pixel written to addr 0.
REQ-040 Sof at address counter 5 in WRITE -> frame_error one-cycle pulse, that pixel written to addr 0, next to addr 1, frame_count unchanged.
REQ-041 pix_valid toggled 1/0 every cycle over full frame -> 8 writes, ascending addresses, correct data, completion as in REQ-037.
REQ-042 rst asserted at address 3 and in WAIT_DET -> all outputs at REQ-035 values immediately; 256 completed frames -> frame_count wraps to 0.
